// File: rtl/dnn_accel_pkg.sv
// Shared types and constants for the dot-product accelerator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dnn_accel_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;

    // CPU-visible register word offsets
    localparam logic [3:0] OFF_CTRL   = 4'd0;  // write: start, read: result
    localparam logic [3:0] OFF_WBASE  = 4'd2;
    localparam logic [3:0] OFF_ABASE  = 4'd3;
    localparam logic [3:0] OFF_LEN    = 4'd5;
    localparam logic [3:0] OFF_STATUS = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_W  = 3'd1,
        ST_WAIT_W = 3'd2,
        ST_REQ_A  = 3'd3,
        ST_WAIT_A = 3'd4,
        ST_MAC    = 3'd5
    } state_t;

    // Byte address of element idx in a word array starting at base (wraps).
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [31:0]       idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/dot_accel_if.sv
// Avalon-MM style bus bundle used for both the CPU slave port and the SDRAM master port.
// Latency: n/a (wires only).
// Backpressure: waitrequest from the slave side stalls the master's request.
interface dot_accel_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          waitrequest;
    logic          readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/dot_accel_mac.sv
// fixed_mac: Q16.16 signed multiply, rescale (floor) and wrapping accumulate.
// Latency: combinational.
// Backpressure: none.
module fixed_mac
    import dnn_accel_pkg::*;
(
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] acc_out
);
    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] prod;

    assign w_ext = {{DATA_W{w[DATA_W-1]}}, w};
    assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign prod  = w_ext * a_ext;

    // Arithmetic shift floors toward -inf; keeping the low word wraps mod 2^32.
    assign acc_out = acc_in + DATA_W'(prod >>> FRAC_BITS);
endmodule

// File: rtl/dot_accel.sv
// Dot-product engine: CPU-programmed bases/length, streams weight/activation pairs from SDRAM, Q16.16 MAC.
// Latency: >= 5 cycles per element (REQ_W, WAIT_W, REQ_A, WAIT_A, MAC) plus SDRAM wait/return latency.
// Backpressure: holds master read/address while waitrequest=1; stalls CPU result reads until done.
module dot_accel
    import dnn_accel_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    dot_accel_if.slave  csr,
    dot_accel_if.master mem
);
    state_t              state;
    logic [ADDR_W-1:0]   wbase;
    logic [ADDR_W-1:0]   abase;
    logic [31:0]         len;
    logic [31:0]         idx;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   mac_out;
    logic                done;
    logic                mem_read;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   csr_rdata;
    logic                wr_en;
    logic                start;

    // Any write while the engine is busy is dropped, start included.
    assign wr_en = csr.write && done;
    assign start = wr_en && (csr.address == OFF_CTRL);

    fixed_mac u_mac (
        .acc_in  (acc),
        .w       (w_q),
        .a       (a_q),
        .acc_out (mac_out)
    );

    // Configuration registers, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbase <= '0;
            abase <= '0;
            len   <= '0;
        end else if (wr_en) begin
            case (csr.address)
                OFF_WBASE: wbase <= csr.writedata;
                OFF_ABASE: abase <= csr.writedata;
                OFF_LEN:   len   <= csr.writedata;
                default: ;
            endcase
        end
    end

    // Sequencer: one SDRAM read in flight, weight then activation, then accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            acc      <= '0;
            w_q      <= '0;
            a_q      <= '0;
            done     <= 1'b1;
            mem_read <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!done) begin
                        // Zero-length run: report completion one cycle after start.
                        done <= 1'b1;
                    end else if (start) begin
                        idx  <= '0;
                        acc  <= '0;
                        done <= 1'b0;
                        if (len != '0) begin
                            state    <= ST_REQ_W;
                            mem_read <= 1'b1;
                            mem_addr <= wbase;
                        end
                    end
                end
                ST_REQ_W: begin
                    if (!mem.waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= ST_WAIT_W;
                    end
                end
                ST_WAIT_W: begin
                    if (mem.readdatavalid) begin
                        w_q      <= mem.readdata;
                        mem_read <= 1'b1;
                        mem_addr <= elem_addr(abase, idx);
                        state    <= ST_REQ_A;
                    end
                end
                ST_REQ_A: begin
                    if (!mem.waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= ST_WAIT_A;
                    end
                end
                ST_WAIT_A: begin
                    if (mem.readdatavalid) begin
                        a_q   <= mem.readdata;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= mac_out;
                    if (idx + 32'd1 == len) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        idx      <= idx + 32'd1;
                        mem_read <= 1'b1;
                        mem_addr <= elem_addr(wbase, idx + 32'd1);
                        state    <= ST_REQ_W;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // CPU read mux; result reads are held off by waitrequest while busy.
    always_comb begin
        csr_rdata = '0;
        if (csr.read && !csr.write) begin
            case (csr.address)
                OFF_CTRL:   csr_rdata = acc;
                OFF_WBASE:  csr_rdata = wbase;
                OFF_ABASE:  csr_rdata = abase;
                OFF_LEN:    csr_rdata = len;
                OFF_STATUS: csr_rdata = {{(DATA_W-1){1'b0}}, done};
                default:    csr_rdata = '0;
            endcase
        end
    end

    assign csr.readdata      = csr_rdata;
    assign csr.waitrequest   = csr.read && !csr.write && (csr.address == OFF_CTRL) && !done;
    assign csr.readdatavalid = 1'b0;

    assign mem.address   = mem_addr;
    assign mem.read      = mem_read;
    assign mem.write     = 1'b0;
    assign mem.writedata = '0;
endmodule
